// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract controller around one full adder cell; optional abort via SERIAL_ADDER_ABORT_EN

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic res
);

  assign res  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // The top result bit goes straight from the adder into result, so SR keeps only the lower WIDTH-1 bits.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             run_step;
  logic             c_msb;
  logic [WIDTH-1:0] sr_wide;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .cout (fa_cout),
    .res  (fa_sum)
  );

  assign sr_wide = {fa_sum, sr_q};
  assign c_msb   = carry_q;

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sr_d       = sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    run_step   = 1'b0;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          sa_d    = op_a;
          sb_d    = op_b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef SERIAL_ADDER_ABORT_EN
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          run_step = 1'b1;
        end
`else
        run_step = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (run_step) begin
      sa_d    = {1'b0, sa_q[WIDTH-1:1]};
      sb_d    = {1'b0, sb_q[WIDTH-1:1]};
      sr_d    = sr_wide[WIDTH-1:1];
      carry_d = fa_cout;
      cnt_d   = cnt_q + CW'(1);
      // Outputs only move on the final bit, so they never expose a partial sum.
      if (cnt_q == LAST_BIT) begin
        state_d    = S_FIN;
        result_d   = sr_wide;
        cout_d     = fa_cout;
        overflow_d = c_msb ^ fa_cout;
        done_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      sr_q       <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sr_q       <= sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl with directed vectors

module tb_serial_adder_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
`ifdef SERIAL_ADDER_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
`ifdef SERIAL_ADDER_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    int               due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("cout", 64'(cout), 64'(e.co));
        check("overflow", 64'(overflow), 64'(e.ov));
        check("done_cycle", 64'(cycle), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       input logic push, input logic [WIDTH-1:0] er, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    e.res = er;
    e.co  = eco;
    e.ov  = eov;
    e.due = cycle + 1 + WIDTH;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_result", 64'(result), 64'd0);
    check("idle_cout", 64'(cout), 64'd0);
    check("idle_overflow", 64'(overflow), 64'd0);

    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    wait_idle();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_idle();
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // Start held through RUN with garbage operands, then a second op accepted in FIN.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 32'h0000_0010; op_b = 32'h0000_0020;
    e.res = 32'h0000_0030; e.co = 1'b0; e.ov = 1'b0; e.due = cycle + 1 + WIDTH;
    sb_q.push_back(e);
    for (int j = 1; j <= WIDTH; j++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom; sub = 1'b1;
    end
    @(negedge clk);
    check("fin_busy", 64'(busy), 64'd0);
    sub = 1'b1; op_a = 32'h0000_0100; op_b = 32'h0000_0001;
    e.res = 32'h0000_00FF; e.co = 1'b1; e.ov = 1'b0; e.due = cycle + 1 + WIDTH;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_idle();

    // Reset mid-operation.
    issue(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    wait_idle();

`ifdef SERIAL_ADDER_ABORT_EN
    issue(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'h2);
    repeat (40) @(negedge clk);
    check("abort_done", 64'(done), 64'd0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled on the rising edge.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B; sampled together with start.
REQ-006 The block SHALL have port op_a, input, WIDTH bits: operand A, sampled together with start.
REQ-007 The block SHALL have port op_b, input, WIDTH bits: operand B, sampled together with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that result, cout and overflow are updated.
REQ-010 The block SHALL have port result, output, WIDTH bits: registered sum or difference.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry out (for sub=1, 1 means no borrow).
REQ-012 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow of the last operation.

Function
REQ-013 The block SHALL compute with exactly one instance of the team 1-bit full adder cell (ports a, b, cin, cout, res), one bit per cycle, LSB first.
REQ-014 The FSM SHALL have states IDLE, RUN and FIN.
REQ-015 In IDLE or FIN, start=1 SHALL latch A into shift register SA, B^{WIDTH{sub}} into SB, carry register to sub and bit counter to 0, then enter RUN.
REQ-016 In RUN, each cycle SHALL feed SA[0], SB[0] and the carry register into the adder, shift SA and SB right, shift the adder sum into the MSB of shift register SR, load the adder carry into the carry register and increment the counter.
REQ-017 The carry-in of bit WIDTH-1 SHALL be captured as c_msb for overflow.
REQ-018 On the edge that processes bit WIDTH-1, the block SHALL enter FIN and load result<=final SR, cout<=final carry and overflow<=c_msb^final carry.
REQ-019 Latency: with start sampled at edge k, done SHALL be high during the cycle following edge k+WIDTH, for exactly one cycle.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 In FIN with start=0, the block SHALL return to IDLE on the next edge.
REQ-022 Start asserted in FIN SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-023 Start asserted while in RUN SHALL be ignored; sub, op_a and op_b changes during RUN SHALL have no effect.
REQ-024 result, cout and overflow SHALL hold their values until the next completion and SHALL never show partial sums.
REQ-025 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL not wrap during an operation.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and regardless of state (including mid-RUN), force IDLE, busy=0, done=0, result=0, cout=0, overflow=0, and clear the counter, SA, SB, SR and the carry register.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-028 Macro SERIAL_ADDER_ABORT_EN defined: the block SHALL add input port abort (1 bit). abort=1 in RUN SHALL return to IDLE on the next edge with no done pulse and result, cout and overflow unchanged. abort SHALL take priority over completion and SHALL be ignored outside RUN.
REQ-029 Macro SERIAL_ADDER_ABORT_EN undefined: the block SHALL have no abort port and no abort logic; all other behaviour SHALL be identical.

Verification
REQ-030 Reset then idle: rst_n=0 then 1, no start -> busy=0, done=0, result=0, cout=0, overflow=0 indefinitely.
REQ-031 Add, WIDTH=32: A=0x00000005, B=0x00000003, sub=0 -> done exactly 33 cycles after the start edge, result=0x00000008, cout=0, overflow=0.
REQ-032 Add boundary: A=0xFFFFFFFF, B=0x00000001 -> result=0, cout=1, overflow=0; then A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1, cout=0.
REQ-033 Subtract: A=3, B=5, sub=1 -> result=0xFFFFFFFE, cout=0; then A=0x80000000, B=1, sub=1 -> result=0x7FFFFFFF, overflow=1, cout=1.
REQ-034 Handshake: start held high through RUN with changing operands -> the first operands' result is produced; start high in FIN -> the next operation begins with busy high on the following cycle and no IDLE cycle.
REQ-035 Reset or abort mid-operation: rst_n pulsed low at bit 10 -> outputs cleared immediately; with SERIAL_ADDER_ABORT_EN, abort at bit 10 -> IDLE next cycle, no done, previous result retained.
